// File: rtl/bus_periph_timer.sv
// bus_periph_timer: GPIO + 16-bit down-counting timer behind a 16-byte CPU register window.
// Latency: writes take effect on the edge that samples them; read data and rd_hit follow one clock after the read address.
// Backpressure: none; the CPU bus has no strobe, so every cycle is a bus cycle and the block is always ready.
//
// Ports:
//    clk, reset_n          core clock, asynchronous active-low reset
//    addr, rw, wdata       CPU address, RW (1 = read, 0 = write), write data
//    rdata, rd_hit         registered read data and its valid flag for the CPU data_in mux
//    gpio_in, gpio_out     asynchronous GPIO inputs (2-flop synchronized), GPIO output register
//    irq_n                 active-low timer interrupt, driven straight from a flop
//
// Build option: define BUS_PERIPH_PRESCALER_EN to add the PRESCALE register at offset 0x8.

module bus_periph_timer #(
   parameter logic [15:0] BASE_ADDR = 16'hD000,
   parameter int          GPIO_W    = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [15:0]       addr,
   input  logic              rw,
   input  logic [7:0]        wdata,
   output logic [7:0]        rdata,
   output logic              rd_hit,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out,
   output logic              irq_n
);

   localparam int CTRL_EN     = 0;
   localparam int CTRL_AUTO   = 1;
   localparam int CTRL_IRQ_EN = 2;

   logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
   logic [GPIO_W-1:0] sync1_q, sync1_d;
   logic [GPIO_W-1:0] sync2_q, sync2_d;
   logic [7:0]        reload_lo_q, reload_lo_d;
   logic [7:0]        reload_hi_q, reload_hi_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [2:0]        ctrl_q, ctrl_d;
   logic              exp_q, exp_d;
   logic [7:0]        shadow_q, shadow_d;
   logic [7:0]        rdata_q, rdata_d;
   logic              rd_hit_q, rd_hit_d;
   logic              irq_n_q, irq_n_d;
`ifdef BUS_PERIPH_PRESCALER_EN
   logic [7:0]        prescale_q, prescale_d;
   logic [7:0]        pre_cnt_q, pre_cnt_d;
`endif

   logic       sel;
   logic       wr;
   logic       rd;
   logic [3:0] off;
   logic       tick;
   logic       exp_set;
   logic       exp_clr;

   always_comb begin
      sel = (addr[15:4] == BASE_ADDR[15:4]);
      wr  = sel & ~rw;
      rd  = sel & rw;
      off = addr[3:0];

      gpio_out_d  = gpio_out_q;
      sync1_d     = gpio_in;
      sync2_d     = sync1_q;
      reload_lo_d = reload_lo_q;
      reload_hi_d = reload_hi_q;
      cnt_d       = cnt_q;
      ctrl_d      = ctrl_q;
      shadow_d    = shadow_q;
      rdata_d     = rdata_q;
      rd_hit_d    = rd;
      exp_set     = 1'b0;
      exp_clr     = 1'b0;

`ifdef BUS_PERIPH_PRESCALER_EN
      prescale_d = prescale_q;
      pre_cnt_d  = pre_cnt_q;
      tick       = (pre_cnt_q == prescale_q);
      if (ctrl_q[CTRL_EN]) begin
         pre_cnt_d = tick ? 8'h00 : pre_cnt_q + 8'h01;
      end
`else
      tick = 1'b1;
`endif

      // Timer step. CPU writes below are applied afterwards so they win over
      // the decrement/reload and over the one-shot auto-clear of EN.
      if (ctrl_q[CTRL_EN] && tick) begin
         if (cnt_q != 16'h0000) begin
            cnt_d = cnt_q - 16'h0001;
         end else begin
            exp_set = 1'b1;
            if (ctrl_q[CTRL_AUTO]) begin
               cnt_d = {reload_hi_q, reload_lo_q};
            end else begin
               ctrl_d[CTRL_EN] = 1'b0;
            end
         end
      end

      if (wr) begin
         case (off)
            4'h0: gpio_out_d = wdata[GPIO_W-1:0];
            4'h2: reload_lo_d = wdata;
            4'h3: begin
               reload_hi_d = wdata;
               cnt_d       = {wdata, reload_lo_q};
`ifdef BUS_PERIPH_PRESCALER_EN
               pre_cnt_d   = 8'h00;
`endif
            end
            4'h4: begin
               ctrl_d = wdata[2:0];
`ifdef BUS_PERIPH_PRESCALER_EN
               pre_cnt_d = 8'h00;
`endif
            end
            4'h5: exp_clr = wdata[0];
`ifdef BUS_PERIPH_PRESCALER_EN
            4'h8: prescale_d = wdata;
`endif
            default: ;
         endcase
      end

      // Set beats clear when expiry and a write-1-clear land on the same edge.
      exp_d   = exp_set | (exp_q & ~exp_clr);
      irq_n_d = ~(exp_d & ctrl_d[CTRL_IRQ_EN]);

      if (rd) begin
         case (off)
            4'h0: rdata_d = 8'(gpio_out_q);
            4'h1: rdata_d = 8'(sync2_q);
            4'h2: rdata_d = reload_lo_q;
            4'h3: rdata_d = reload_hi_q;
            4'h4: rdata_d = {5'b0, ctrl_q};
            4'h5: rdata_d = {7'b0, exp_q};
            4'h6: begin
               // Capture the high byte now so a following CNT_HI read is
               // coherent with this low byte.
               rdata_d  = cnt_q[7:0];
               shadow_d = cnt_q[15:8];
            end
            4'h7: rdata_d = shadow_q;
`ifdef BUS_PERIPH_PRESCALER_EN
            4'h8: rdata_d = prescale_q;
`endif
            default: rdata_d = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gpio_out_q  <= '0;
         sync1_q     <= '0;
         sync2_q     <= '0;
         reload_lo_q <= 8'h00;
         reload_hi_q <= 8'h00;
         cnt_q       <= 16'h0000;
         ctrl_q      <= 3'b000;
         exp_q       <= 1'b0;
         shadow_q    <= 8'h00;
         rdata_q     <= 8'h00;
         rd_hit_q    <= 1'b0;
         irq_n_q     <= 1'b1;
`ifdef BUS_PERIPH_PRESCALER_EN
         prescale_q  <= 8'h00;
         pre_cnt_q   <= 8'h00;
`endif
      end else begin
         gpio_out_q  <= gpio_out_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         reload_lo_q <= reload_lo_d;
         reload_hi_q <= reload_hi_d;
         cnt_q       <= cnt_d;
         ctrl_q      <= ctrl_d;
         exp_q       <= exp_d;
         shadow_q    <= shadow_d;
         rdata_q     <= rdata_d;
         rd_hit_q    <= rd_hit_d;
         irq_n_q     <= irq_n_d;
`ifdef BUS_PERIPH_PRESCALER_EN
         prescale_q  <= prescale_d;
         pre_cnt_q   <= pre_cnt_d;
`endif
      end
   end

   assign gpio_out = gpio_out_q;
   assign rdata    = rdata_q;
   assign rd_hit   = rd_hit_q;
   assign irq_n    = irq_n_q;

endmodule

// File: tb/tb_bus_periph_timer.sv
// tb_bus_periph_timer: self-checking bench for bus_periph_timer.
// Reads push their expected data to a scoreboard; a negedge monitor pops it when rd_hit is due.
// Direct pin checks cover gpio_out, irq_n and the asynchronous reset.

module tb_bus_periph_timer;

   localparam logic [15:0] BASE = 16'hD000;

   logic        clk;
   logic        reset_n;
   logic [15:0] addr;
   logic        rw;
   logic [7:0]  wdata;
   logic [7:0]  rdata;
   logic        rd_hit;
   logic [7:0]  gpio_in;
   logic [7:0]  gpio_out;
   logic        irq_n;

   int checks;
   int errors;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
   } rd_exp_t;

   rd_exp_t sb_q[$];
   logic    rd_pending;

   bus_periph_timer #(.BASE_ADDR(BASE), .GPIO_W(8)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .addr     (addr),
      .rw       (rw),
      .wdata    (wdata),
      .rdata    (rdata),
      .rd_hit   (rd_hit),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .irq_n    (irq_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // A read is due one edge after a window read address is presented.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) rd_pending <= 1'b0;
      else          rd_pending <= (addr[15:4] == BASE[15:4]) && rw;
   end

   always @(negedge clk) begin
      rd_exp_t e;
      check_val("rd_hit", {15'b0, rd_hit}, {15'b0, rd_pending});
      if (rd_pending) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: rd_hit with no expected read (t=%0t)", $time);
         end else begin
            e = sb_q.pop_front();
            check_val($sformatf("rdata_%h", e.a), {8'h00, rdata}, {8'h00, e.d});
         end
      end
   end

   // All bus tasks are entered just after a negedge and return just after the next one.
   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      addr  = a;
      rw    = 1'b0;
      wdata = d;
      @(negedge clk);
      addr  = 16'h0000;
      rw    = 1'b1;
   endtask

   task automatic bus_read(input logic [15:0] a, input logic [7:0] d);
      rd_exp_t e;
      e.a = a;
      e.d = d;
      sb_q.push_back(e);
      addr = a;
      rw   = 1'b1;
      @(negedge clk);
      addr = 16'h0000;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      reset_n = 1'b0;
      addr    = 16'h0000;
      rw      = 1'b1;
      wdata   = 8'h00;
      gpio_in = 8'h00;

      #7;
      check_val("rst_irq_n",  {15'b0, irq_n}, 16'h0001);
      check_val("rst_rd_hit", {15'b0, rd_hit}, 16'h0000);
      check_val("rst_rdata",  {8'h00, rdata}, 16'h0000);
      check_val("rst_gpio",   {8'h00, gpio_out}, 16'h0000);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      bus_read(16'hD004, 8'h00);
      bus_read(16'hD005, 8'h00);
      bus_read(16'hD006, 8'h00);

      // GPIO out and input synchronizer latency
      bus_write(16'hD000, 8'hA5);
      check_val("gpio_out", {8'h00, gpio_out}, 16'h00A5);
      gpio_in = 8'h3C;
      bus_read(16'hD001, 8'h00);
      bus_read(16'hD001, 8'h00);
      bus_read(16'hD001, 8'h3C);
      bus_read(16'hD000, 8'hA5);

      // Unmapped offsets and out-of-window addresses
      bus_write(16'hD00A, 8'hFF);
      bus_read(16'hD00A, 8'h00);
      addr = 16'hD010;
      rw   = 1'b1;
      @(negedge clk);
      addr = 16'h0000;
`ifndef BUS_PERIPH_PRESCALER_EN
      bus_write(16'hD008, 8'h55);
      bus_read(16'hD008, 8'h00);
`endif

      // One-shot: reload 4 -> expiry on the 5th tick after enable
      bus_write(16'hD002, 8'h04);
      bus_write(16'hD003, 8'h00);
      bus_write(16'hD004, 8'h05);
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         check_val($sformatf("oneshot_irq_%0d", i), {15'b0, irq_n}, (i == 5) ? 16'h0000 : 16'h0001);
      end
      bus_read(16'hD004, 8'h04);
      bus_read(16'hD005, 8'h01);
      bus_read(16'hD006, 8'h00);
      bus_read(16'hD007, 8'h00);
      bus_write(16'hD005, 8'h00);
      check_val("w0_no_clear", {15'b0, irq_n}, 16'h0000);
      bus_write(16'hD005, 8'h01);
      check_val("w1_clear", {15'b0, irq_n}, 16'h0001);
      bus_read(16'hD005, 8'h00);

      // Auto-reload, reload 2: expiry on E3, E6, E9 after enable edge E0
      bus_write(16'hD004, 8'h00);
      bus_write(16'hD002, 8'h02);
      bus_write(16'hD003, 8'h00);
      bus_write(16'hD004, 8'h03);          // E0
      idle(2);                             // E1, E2
      bus_read(16'hD005, 8'h00);           // E3 (expires)
      bus_write(16'hD005, 8'h01);          // E4 clear
      bus_read(16'hD005, 8'h00);           // E5
      bus_write(16'hD005, 8'h01);          // E6 clear on expiry edge
      bus_read(16'hD005, 8'h01);           // E7: set won
      bus_write(16'hD005, 8'h01);          // E8 clear
      bus_read(16'hD005, 8'h00);           // E9 (expires)
      bus_read(16'hD005, 8'h01);           // E10
      check_val("auto_no_irq", {15'b0, irq_n}, 16'h0001);
      bus_write(16'hD004, 8'h00);
      bus_write(16'hD005, 8'h01);

      // Coherent 16-bit read and RELOAD_HI write beating a decrement
      bus_write(16'hD002, 8'h00);
      bus_write(16'hD003, 8'h01);
      bus_write(16'hD004, 8'h01);
      bus_read(16'hD006, 8'h00);           // counter 0100
      bus_read(16'hD007, 8'h01);           // counter now 00FF, shadow 01
      bus_read(16'hD006, 8'hFE);
      bus_read(16'hD007, 8'h00);
      bus_write(16'hD003, 8'h01);
      bus_read(16'hD006, 8'h00);
      bus_read(16'hD007, 8'h01);
      bus_write(16'hD004, 8'h00);

`ifdef BUS_PERIPH_PRESCALER_EN
      // Prescale 3, reload 1: expiry 8 clocks after enable
      bus_write(16'hD008, 8'h03);
      bus_read(16'hD008, 8'h03);
      bus_write(16'hD002, 8'h01);
      bus_write(16'hD003, 8'h00);
      bus_write(16'hD004, 8'h01);          // E0
      idle(7);                             // E1..E7
      bus_read(16'hD005, 8'h00);           // E8 (expires)
      bus_read(16'hD005, 8'h01);
      bus_write(16'hD004, 8'h00);
      bus_write(16'hD005, 8'h01);
`endif

      // Asynchronous reset mid-count with EXP=1 and a read just returned
      bus_write(16'hD002, 8'h00);
      bus_write(16'hD003, 8'h00);
      bus_write(16'hD004, 8'h07);
      @(negedge clk);
      check_val("pre_rst_irq", {15'b0, irq_n}, 16'h0000);
      bus_read(16'hD004, 8'h07);
      #2;
      reset_n = 1'b0;
      #1;
      check_val("arst_irq_n",  {15'b0, irq_n}, 16'h0001);
      check_val("arst_gpio",   {8'h00, gpio_out}, 16'h0000);
      check_val("arst_rd_hit", {15'b0, rd_hit}, 16'h0000);
      check_val("arst_rdata",  {8'h00, rdata}, 16'h0000);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      bus_read(16'hD004, 8'h00);
      bus_read(16'hD000, 8'h00);
      bus_read(16'hD005, 8'h00);
      bus_read(16'hD006, 8'h00);

      idle(2);
      check_val("sb_drain", 16'(sb_q.size()), 16'h0000);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_periph_timer.md
Name: bus_periph_timer

Overview:
- Bus responder on the 6502 CPU core bus: decodes a 16-byte window at BASE_ADDR and serves reads and writes from the CPU.
- Contains a GPIO output register, a synchronized GPIO input, and a 16-bit down-counting timer with an active-low interrupt output.
- Sits beside the CPU core inside the padded top. Its read data is muxed into CPU data_in, and irq_n is available for the CPU IRQ input.

Parameters:
- BASE_ADDR, 16'hD000, base of the 16-byte register window; low 4 bits must be 0.
- GPIO_W, 8, width of gpio_in and gpio_out (1..8).

Ports:
- clk  input  1  core clock, same clock as the CPU.
- reset_n  input  1  asynchronous active-low reset.
- addr  input  16  CPU address.
- rw  input  1  CPU RW: 1 = read, 0 = write.
- wdata  input  8  CPU write data (CPU data_out).
- rdata  output  8  registered read data to the CPU data_in mux.
- rd_hit  output  1  high in the cycle rdata carries a valid window read; selects rdata in the mux.
- gpio_in  input  GPIO_W  asynchronous external inputs.
- gpio_out  output  GPIO_W  GPIO output register.
- irq_n  output  1  active-low timer interrupt.

Behaviour:
- Select: sel = (addr[15:4] == BASE_ADDR[15:4]). Every cycle is treated as a bus cycle, because the CPU has no strobe.
- Write: on the rising clk edge with sel & !rw, register addr[3:0] takes wdata.
- Read: with sel & rw in cycle N, rdata and rd_hit=1 are presented in cycle N+1 (1-cycle synchronous latency).
  - Cycle N+1 with no read in cycle N: rd_hit=0 and rdata holds its last value.
  - Unmapped offsets read 8'h00 with rd_hit=1. Writes to them are ignored.
- Register map (offset, access, function):
  - 0x0 RW GPIO_OUT, drives gpio_out[GPIO_W-1:0]. Upper bits read 0.
  - 0x1 RO GPIO_IN, 2-flop synchronized gpio_in. Input-to-readable latency is 2 clocks.
  - 0x2 RW RELOAD_LO.
  - 0x3 RW RELOAD_HI. A write also loads counter <= {wdata, RELOAD_LO}.
  - 0x4 RW CTRL: bit0 EN, bit1 AUTO, bit2 IRQ_EN. Bits 7:3 read 0.
  - 0x5 STATUS: bit0 EXP. Write 1 clears it; write 0 has no effect.
  - 0x6 RO CNT_LO, live counter[7:0]. Reading it latches counter[15:8] into the HI shadow in the same edge.
  - 0x7 RO CNT_HI, the shadow value. This gives a coherent 16-bit read.
- Timer rules, evaluated on each tick (every clk, unless the optional feature applies) while EN=1:
  - If counter != 0: counter <= counter - 1.
  - If counter == 0: EXP <= 1. Then, if AUTO=1, counter <= {RELOAD_HI, RELOAD_LO}; otherwise EN <= 0 and counter stays 0.
  - Period = reload + 1 ticks. Reload 0 with AUTO gives EXP on every tick.
  - EN=0: counter frozen.
- Simultaneous events:
  - Expiry and a write-1-clear of EXP in the same edge: set wins, EXP=1.
  - A RELOAD_HI write in the same edge as a decrement or expiry: the write wins for the counter value; EXP is still set if that tick expired.
  - A CPU write of CTRL.EN=1 in the same edge as an auto-clear of EN: the CPU write wins.
- irq_n = !(EXP & IRQ_EN). It is registered-clean: it is driven only from flops.
- Reset (asynchronous, any time, including mid-count or mid-read):
  - All registers go to 0: gpio_out, RELOAD, counter, CTRL, EXP, shadow, synchronizer flops.
  - rdata = 8'h00, rd_hit = 0, irq_n = 1.

Optional Feature:
- Macro: BUS_PERIPH_PRESCALER_EN.
- When defined:
  - Offset 0x8 is an RW 8-bit PRESCALE register, reset 0.
  - An internal 8-bit prescale counter generates one tick every PRESCALE+1 clocks while EN=1.
  - The prescale counter restarts at 0 on any RELOAD_HI or CTRL write.
- When undefined:
  - tick = 1 every clock.
  - Offset 0x8 is unmapped: reads 0, writes ignored.

Test Plan:
- Reset: assert reset_n=0 mid-count with EXP=1 -> immediately irq_n=1, gpio_out=0, rd_hit=0. After release, read 0x4 -> 8'h00.
- GPIO: write 8'hA5 to 16'hD000 -> gpio_out=8'hA5 next edge. Drive gpio_in=8'h3C; read 16'hD001 three clocks later -> rdata=8'h3C, rd_hit=1 exactly one cycle after the read address.
- One-shot timer: RELOAD_LO=8'h04, RELOAD_HI=8'h00, CTRL=8'h05 -> EXP=1 and irq_n=0 on the 5th tick after enable. Then CTRL.EN reads 0 and the counter stays 0. Write 8'h01 to 0x5 -> irq_n=1.
- Auto-reload: reload 16'h0002, CTRL=8'h03 -> EXP sets every 3 clocks. Clear it on the exact expiry edge -> EXP stays 1 (set wins).
- Coherent read: reload 16'h0100 with EN. Read 0x6 at counter=16'h0100 -> rdata 8'h00. Read 0x7 after the counter crosses to 16'h00FF -> rdata 8'h01 (shadow).
- Prescaler (macro on): PRESCALE=8'h03, reload 16'h0001, EN -> EXP after 8 clocks. With the macro off, a read of 0x8 -> 8'h00.
